hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised successor to the pipeline hazard unit: sequential stall/flush controller plus forwarding-select generator for the 5-stage core (fetch, decode, execute, memory access, write back). Adds load-use stall sequencing, full-pipe freeze on data-cache miss, and multi-cycle mispredict flush via a small FSM. Optional performance counters are included. Sits beside the pipeline registers; drives every stage enable and flush.

## Interface
- XLEN, 32, address/data width
- NUM_REGS, 32, register count; RW = $clog2(NUM_REGS)
- LOAD_LATENCY, 2, decode-hold cycles after a load-use hit (≥1)
- FLUSH_CYCLES, 1, bubble cycles issued after a mispredict (≥1)
- PERF_W, 32, perf counter width
- i_aclk  in  1  clock
- i_areset  in  1  asynchronous reset, active-high
- i_fetch_instr_valid  in  1  fetch output valid
- i_decode_br_valid / i_decode_br_addr  in  1 / XLEN  predicted branch from decode
- i_decode_pc  in  XLEN  PC of instruction in decode
- i_decode_rs1, i_decode_rs2  in  RW  decode source regs
- i_exe_br_valid / i_exe_br_addr  in  1 / XLEN  resolved branch from execute
- i_exe_rs1, i_exe_rs2, i_exe_rdest  in  RW  execute regs
- i_exe_regwrite  in  1; i_exe_memtoreg  in  2
- i_ma_cache_ready, i_ma_memaccess, i_ma_regwrite  in  1
- i_ma_memtoreg  in  2; i_ma_rdest  in  RW
- i_wb_regwrite  in  1; i_wb_rdest  in  RW
- o_br_valid / o_br_addr  out  1 / XLEN  redirect to fetch
- o_fetch_en, o_decode_en, o_exe_en, o_ma_en  out  1  stage enables (0 = hold)
- o_decode_flush, o_exe_flush  out  1  load NOP into stage register
- o_decode_fwd_a/b, o_exe_fwd_a/b  out  2  00 none, 01 MA, 10 WB
- o_perf_load_stalls, o_perf_mem_stalls, o_perf_flushes  out  PERF_W  (HAZARD_PERF_EN only)

## Operation
- Derived: mem_stall = i_ma_memaccess & ~i_ma_cache_ready; mispredict = i_exe_br_valid & (i_decode_pc != i_exe_br_addr); load_use = i_exe_regwrite & i_exe_memtoreg==MEM & i_exe_rdest!=0 & (i_exe_rdest==i_decode_rs1 | i_exe_rdest==i_decode_rs2).
- Forwarding per operand: MA hit (rdest match, rs≠0, regwrite, memtoreg ALU or PC4) → 01; else WB hit (match, rs≠0, regwrite) → 10; else 00. MA wins over WB.
- FSM states RUN, LOAD_STALL, FLUSH; down-counter cnt. Priority per cycle: mem_stall > mispredict > current state > load_use.
- mem_stall: all four enables 0, flushes 0, o_br_valid 0, state/cnt held.
- mispredict (not mem_stall): o_br_valid=1, o_br_addr=i_exe_br_addr, o_decode_flush=o_exe_flush=1; if FLUSH_CYCLES>1 → FLUSH, cnt=FLUSH_CYCLES-1, else RUN. Cancels any LOAD_STALL.
- FLUSH: o_decode_flush=1, decode branches ignored, fetch enabled; cnt-- ; at cnt==1 → RUN.
- RUN & load_use: o_fetch_en=o_decode_en=0, o_exe_flush=1 → LOAD_STALL, cnt=LOAD_LATENCY-1 (LOAD_LATENCY==1 stays RUN).
- LOAD_STALL: fetch/decode held, o_exe_flush=1; cnt-- ; at cnt==1 → RUN.
- RUN otherwise: o_br_valid=i_decode_br_valid, o_br_addr=i_decode_br_addr, o_decode_en=i_fetch_instr_valid, others 1.
- o_ma_en = ~mem_stall outside reset.

## Timing
- Forwarding selects and enables combinational from inputs and registered state; state/cnt registered on i_aclk rising edge.
- While i_areset=1 and the first cycle after release: enables 0, flushes 0, o_br_valid 0, o_br_addr 0, fwd 00, state RUN, cnt 0, perf 0.
- Load-use hold lasts exactly LOAD_LATENCY unstalled cycles; mem_stall cycles extend it, not shorten it.
- Reset mid-stall/flush: immediate return to reset values; no residual bubbles.
- Redirect issued exactly once; a mispredict under mem_stall is issued on the first non-stalled cycle.

## Configuration
- HAZARD_PERF_EN defined: three saturating PERF_W counters (load-stall cycles, mem-stall cycles, mispredict events), cleared only by reset. Undefined: ports and logic absent; otherwise identical behaviour.

## Structure
- multicore_pkg: hazard_state_t {RUN, LOAD_STALL, FLUSH}, fwd_sel_t {FWD_NONE=2'b00, FWD_MA=2'b01, FWD_WB=2'b10}, memtoreg encodings MTR_ALU=00, MTR_MEM=01, MTR_PC4=10, NUM_REGS.
- Sub-module hazard_fwd_sel: one operand's forwarding select; instantiated four times.

## Test plan
- MA: rdest=5, regwrite=1, memtoreg=ALU; decode_rs1=5, WB also rdest=5 → o_decode_fwd_a=01; rs1=0 → 00.
- Exe load to x7, decode_rs2=7, LOAD_LATENCY=2 → fetch/decode held 2 cycles, o_exe_flush=1 both, then RUN with WB forward 10.
- i_exe_br_valid=1, addr=0x100, decode_pc=0x104, FLUSH_CYCLES=3 → o_br_valid one cycle with 0x100, decode flush 3 cycles, exe flush 1.
- Same but decode_pc=0x100 → no redirect, no flush.
- memaccess=1, cache_ready=0 for 4 cycles during LOAD_STALL → all enables 0, stall resumes remaining cycle afterward; mem_stall perf +4.
- Assert i_areset in FLUSH with cnt=2 → all outputs reset values immediately, RUN after release.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared types and encodings for the 5-stage core's hazard control.
// Holds FSM states, forwarding-select and write-back source encodings.
package multicore_pkg;

    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        FLUSH      = 2'b10
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MA   = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for a single source operand.
// Memory-access results win over write-back; loads in memory access are not yet usable.
module hazard_fwd_sel
    import multicore_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] rs,
    input  logic          ma_regwrite,
    input  logic [1:0]    ma_memtoreg,
    input  logic [RW-1:0] ma_rdest,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rdest,
    output logic [1:0]    sel
);

    logic ma_hit;
    logic wb_hit;

    always_comb begin
        ma_hit = ma_regwrite && (rs != '0) && (ma_rdest == rs) &&
                 ((ma_memtoreg == MTR_ALU) || (ma_memtoreg == MTR_PC4));
        wb_hit = wb_regwrite && (rs != '0) && (wb_rdest == rs);
        sel    = FWD_NONE;
        if (ma_hit) begin
            sel = FWD_MA;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer and forwarding-select generator for the 5-stage core.
// Define HAZARD_PERF_EN to add saturating load-stall, mem-stall and mispredict counters.
//
// state      | meaning
// RUN        | normal flow, decode branch predictions passed to fetch
// LOAD_STALL | fetch/decode held, bubble into execute until load data is forwardable
// FLUSH      | bubbles into decode after a mispredict redirect
module hazard_ctrl
    import multicore_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = multicore_pkg::NUM_REGS,
    parameter int LOAD_LATENCY = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic              i_aclk,
    input  logic              i_areset,
    input  logic              i_fetch_instr_valid,
    input  logic              i_decode_br_valid,
    input  logic [XLEN-1:0]   i_decode_br_addr,
    input  logic [XLEN-1:0]   i_decode_pc,
    input  logic [RW-1:0]     i_decode_rs1,
    input  logic [RW-1:0]     i_decode_rs2,
    input  logic              i_exe_br_valid,
    input  logic [XLEN-1:0]   i_exe_br_addr,
    input  logic [RW-1:0]     i_exe_rs1,
    input  logic [RW-1:0]     i_exe_rs2,
    input  logic [RW-1:0]     i_exe_rdest,
    input  logic              i_exe_regwrite,
    input  logic [1:0]        i_exe_memtoreg,
    input  logic              i_ma_cache_ready,
    input  logic              i_ma_memaccess,
    input  logic              i_ma_regwrite,
    input  logic [1:0]        i_ma_memtoreg,
    input  logic [RW-1:0]     i_ma_rdest,
    input  logic              i_wb_regwrite,
    input  logic [RW-1:0]     i_wb_rdest,
    output logic              o_br_valid,
    output logic [XLEN-1:0]   o_br_addr,
    output logic              o_fetch_en,
    output logic              o_decode_en,
    output logic              o_exe_en,
    output logic              o_ma_en,
    output logic              o_decode_flush,
    output logic              o_exe_flush,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] o_perf_load_stalls,
    output logic [PERF_W-1:0] o_perf_mem_stalls,
    output logic [PERF_W-1:0] o_perf_flushes,
`endif
    output logic [1:0]        o_decode_fwd_a,
    output logic [1:0]        o_decode_fwd_b,
    output logic [1:0]        o_exe_fwd_a,
    output logic [1:0]        o_exe_fwd_b
);

    localparam int CNT_MAX = (LOAD_LATENCY > FLUSH_CYCLES) ? LOAD_LATENCY : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (LOAD_LATENCY < 1 || FLUSH_CYCLES < 1 || PERF_W < 1) begin : g_bad_param
        $error("hazard_ctrl: LOAD_LATENCY, FLUSH_CYCLES and PERF_W must be >= 1");
    end

    hazard_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             active;
    logic             mem_stall;
    logic             mispredict;
    logic             load_use;
    logic [1:0]       dec_fwd_a, dec_fwd_b, exe_fwd_a, exe_fwd_b;

    // active stays low through reset and the first cycle after release
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state  <= RUN;
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            active <= 1'b1;
        end
    end

    always_comb begin
        mem_stall  = i_ma_memaccess & ~i_ma_cache_ready;
        mispredict = i_exe_br_valid & (i_decode_pc != i_exe_br_addr);
        load_use   = i_exe_regwrite && (i_exe_memtoreg == MTR_MEM) && (i_exe_rdest != '0) &&
                     ((i_exe_rdest == i_decode_rs1) || (i_exe_rdest == i_decode_rs2));
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        o_br_valid     = 1'b0;
        o_br_addr      = '0;
        o_fetch_en     = 1'b0;
        o_decode_en    = 1'b0;
        o_exe_en       = 1'b0;
        o_ma_en        = 1'b0;
        o_decode_flush = 1'b0;
        o_exe_flush    = 1'b0;

        if (!active || mem_stall) begin
            // freeze everything; a pending mispredict re-presents once the cache returns
        end else if (mispredict) begin
            o_br_valid     = 1'b1;
            o_br_addr      = i_exe_br_addr;
            o_fetch_en     = 1'b1;
            o_decode_en    = 1'b1;
            o_exe_en       = 1'b1;
            o_ma_en        = 1'b1;
            o_decode_flush = 1'b1;
            o_exe_flush    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end else begin
            unique case (state)
                FLUSH: begin
                    o_fetch_en     = 1'b1;
                    o_decode_en    = 1'b1;
                    o_exe_en       = 1'b1;
                    o_ma_en        = 1'b1;
                    o_decode_flush = 1'b1;
                    cnt_nxt        = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = RUN;
                end
                LOAD_STALL: begin
                    o_exe_en    = 1'b1;
                    o_ma_en     = 1'b1;
                    o_exe_flush = 1'b1;
                    cnt_nxt     = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = RUN;
                end
                default: begin
                    if (load_use) begin
                        o_exe_en    = 1'b1;
                        o_ma_en     = 1'b1;
                        o_exe_flush = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            state_nxt = LOAD_STALL;
                            cnt_nxt   = CNT_W'(LOAD_LATENCY - 1);
                        end
                    end else begin
                        o_br_valid  = i_decode_br_valid;
                        o_br_addr   = i_decode_br_addr;
                        o_fetch_en  = 1'b1;
                        o_decode_en = i_fetch_instr_valid;
                        o_exe_en    = 1'b1;
                        o_ma_en     = 1'b1;
                    end
                end
            endcase
        end
    end

    hazard_fwd_sel #(.RW(RW)) u_fwd_dec_a (
        .rs(i_decode_rs1), .ma_regwrite(i_ma_regwrite), .ma_memtoreg(i_ma_memtoreg),
        .ma_rdest(i_ma_rdest), .wb_regwrite(i_wb_regwrite), .wb_rdest(i_wb_rdest), .sel(dec_fwd_a)
    );
    hazard_fwd_sel #(.RW(RW)) u_fwd_dec_b (
        .rs(i_decode_rs2), .ma_regwrite(i_ma_regwrite), .ma_memtoreg(i_ma_memtoreg),
        .ma_rdest(i_ma_rdest), .wb_regwrite(i_wb_regwrite), .wb_rdest(i_wb_rdest), .sel(dec_fwd_b)
    );
    hazard_fwd_sel #(.RW(RW)) u_fwd_exe_a (
        .rs(i_exe_rs1), .ma_regwrite(i_ma_regwrite), .ma_memtoreg(i_ma_memtoreg),
        .ma_rdest(i_ma_rdest), .wb_regwrite(i_wb_regwrite), .wb_rdest(i_wb_rdest), .sel(exe_fwd_a)
    );
    hazard_fwd_sel #(.RW(RW)) u_fwd_exe_b (
        .rs(i_exe_rs2), .ma_regwrite(i_ma_regwrite), .ma_memtoreg(i_ma_memtoreg),
        .ma_rdest(i_ma_rdest), .wb_regwrite(i_wb_regwrite), .wb_rdest(i_wb_rdest), .sel(exe_fwd_b)
    );

    always_comb begin
        o_decode_fwd_a = active ? dec_fwd_a : FWD_NONE;
        o_decode_fwd_b = active ? dec_fwd_b : FWD_NONE;
        o_exe_fwd_a    = active ? exe_fwd_a : FWD_NONE;
        o_exe_fwd_b    = active ? exe_fwd_b : FWD_NONE;
    end

`ifdef HAZARD_PERF_EN
    logic              load_stall_cyc;
    logic              mem_stall_cyc;
    logic              flush_evt;
    logic [PERF_W-1:0] perf_load, perf_mem, perf_flush;

    always_comb begin
        load_stall_cyc = active & ~mem_stall & ~mispredict &
                         ((state == LOAD_STALL) | ((state == RUN) & load_use));
        mem_stall_cyc  = active & mem_stall;
        flush_evt      = active & ~mem_stall & mispredict;
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            perf_load  <= '0;
            perf_mem   <= '0;
            perf_flush <= '0;
        end else begin
            if (load_stall_cyc && (perf_load != '1)) perf_load <= perf_load + 1'b1;
            if (mem_stall_cyc && (perf_mem != '1)) perf_mem <= perf_mem + 1'b1;
            if (flush_evt && (perf_flush != '1)) perf_flush <= perf_flush + 1'b1;
        end
    end

    assign o_perf_load_stalls = perf_load;
    assign o_perf_mem_stalls  = perf_mem;
    assign o_perf_flushes     = perf_flush;
`endif

endmodule
